rs_syndrome_calc: RTL

//  Decoder front end for the RS(15,9) GF(16) link. Consumes one 60-bit codeword, as produced by
//  the encoder, and serially evaluates syndromes S_j = C(alpha^j), j=1..NUM_SYND, by Horner's rule,
//  one symbol per clock. Reports per-codeword syndromes and an error flag to the downstream
//  key-equation / Chien stage.

---
 rtl/rs_syndrome_calc_if.sv | 22 ++
 rtl/rs_syndrome_calc.sv | 119 +++++++++++
 2 files changed

// File: rtl/rs_syndrome_calc_if.sv
// Handshake/result bundle between the RS(15,9) syndrome calculator and its neighbours.
// The master drives the codeword and start request; the slave returns syndromes and status.
interface rs_syndrome_calc_if #(
  parameter int NUM_SYND = 6
);
  logic [59:0]             codeWordVector;
  logic                    startSynd;
  logic [4*NUM_SYND-1:0]   syndromeVector;
  logic                    syndromeValid;
  logic                    errorDetected;
  logic                    synBusy;

  modport master (
    output codeWordVector, startSynd,
    input  syndromeVector, syndromeValid, errorDetected, synBusy
  );

  modport slave (
    input  codeWordVector, startSynd,
    output syndromeVector, syndromeValid, errorDetected, synBusy
  );
endinterface

// File: rtl/rs_syndrome_calc.sv
// RS(15,9) GF(16) syndrome calculator: Horner evaluation of S_j = C(alpha^j), one symbol per clock.
// Optional feature macro RS_SYND_RESTART_EN: startSynd outside IDLE aborts and restarts the word.
module rs_syndrome_calc #(
  parameter int NUM_SYND = 6
) (
  input logic               clk,
  input logic               resetN,
  rs_syndrome_calc_if.slave synBus
);

  localparam int N = 15;
  localparam int M = 4;
  localparam logic [M-1:0] FIELD_TAIL = 4'b0011;  // alpha^4 = alpha + 1

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } stateT;

  function automatic logic [M-1:0] gfMul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] prod;
    logic [M-1:0] shifted;
    prod    = '0;
    shifted = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) prod = prod ^ shifted;
      shifted = {shifted[M-2:0], 1'b0} ^ (shifted[M-1] ? FIELD_TAIL : '0);
    end
    return prod;
  endfunction

  function automatic logic [NUM_SYND-1:0][M-1:0] alphaTable();
    logic [NUM_SYND-1:0][M-1:0] tbl;
    logic [M-1:0] pw;
    pw = 4'b0001;
    for (int j = 0; j < NUM_SYND; j++) begin
      pw     = gfMul(pw, 4'b0010);
      tbl[j] = pw;
    end
    return tbl;
  endfunction

  localparam logic [NUM_SYND-1:0][M-1:0] ALPHA = alphaTable();

  stateT                      state;
  stateT                      nextState;
  logic [N*M-1:0]             cwReg;
  logic [3:0]                 symCnt;
  logic [NUM_SYND-1:0][M-1:0] acc;
  logic [M-1:0]               curSym;
  logic                       restartReq;
  logic                       loadWord;
  logic [4*NUM_SYND-1:0]      syndReg;
  logic                       validReg;
  logic                       errReg;

`ifdef RS_SYND_RESTART_EN
  assign restartReq = synBus.startSynd && (state != IDLE);
`else
  assign restartReq = 1'b0;
`endif

  assign loadWord = (state == IDLE && synBus.startSynd) || restartReq;
  assign curSym   = cwReg[{symCnt, 2'b00} +: M];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  // NOTE: default assignment up front keeps this comb block latch-free on every path.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (synBus.startSynd) nextState = ACCUM;
      ACCUM:   if (!restartReq && symCnt == 4'd0) nextState = DONE;
      DONE:    nextState = restartReq ? ACCUM : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    synBus.synBusy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cwReg    <= '0;
      symCnt   <= 4'd14;
      acc      <= '0;
      syndReg  <= '0;
      validReg <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      validReg <= 1'b0;
      if (loadWord) begin
        cwReg  <= synBus.codeWordVector;
        symCnt <= 4'd14;
        acc    <= '0;
      end else if (state == ACCUM) begin
        for (int j = 0; j < NUM_SYND; j++) begin
          acc[j] <= gfMul(acc[j], ALPHA[j]) ^ curSym;
        end
        symCnt <= symCnt - 4'd1;
      end else if (state == DONE) begin
        syndReg  <= acc;
        errReg   <= |acc;
        validReg <= 1'b1;
      end
    end
  end

  assign synBus.syndromeVector = syndReg;
  assign synBus.syndromeValid  = validReg;
  assign synBus.errorDetected  = errReg;

endmodule
